toggle_stim_gen: RTL and testbench

- Synthesizable on-chip stimulus source for the latch-inference demo blocks; drives their i0/i1/i2 inputs.
- Three independent free-running square waves with programmable half-periods, counted in clock cycles.
- A bounded run window ends with a done flag.
- Replaces delay-based bench stimulus so the same pattern can be used on silicon and in gate-level sims.

---
 rtl/toggle_stim_gen_pkg.sv | 11 +
 rtl/toggle_stim_gen_chan.sv | 28 ++
 rtl/toggle_stim_gen.sv | 59 +++++
 tb/tb_toggle_stim_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/toggle_stim_gen_pkg.sv
// toggle_stim_gen_pkg: state encoding and default timing constants for the toggle stimulus generator.
package toggle_stim_gen_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int DEF_P0      = 317;
    localparam int DEF_P1      = 37;
    localparam int DEF_P2      = 57;
    localparam int DEF_RUN_LEN = 3000;
    localparam int DEF_CW      = 12;
endpackage

// File: rtl/toggle_stim_gen_chan.sv
// toggle_chan: one square-wave channel, reload down-counter plus toggle flop.
module toggle_chan #(
    parameter int P  = 37,
    parameter int CW = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic init,
    input  logic en,
    output logic wave
);
    localparam logic [CW-1:0] RELOAD = CW'(P - 1);
    logic [CW-1:0] r_cnt;
    logic          r_wave;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= RELOAD;
            r_wave <= 1'b0;
        end else if (init) begin
            r_cnt  <= RELOAD;
            r_wave <= 1'b0;
        end else if (en) begin
            r_cnt  <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
            r_wave <= (r_cnt == '0) ? ~r_wave : r_wave;
        end
    end
    assign wave = r_wave;
endmodule

// File: rtl/toggle_stim_gen.sv
// toggle_stim_gen: three programmable square waves over a bounded run window with done flag.
module toggle_stim_gen
    import toggle_stim_gen_pkg::*;
#(
    parameter int P0      = DEF_P0,
    parameter int P1      = DEF_P1,
    parameter int P2      = DEF_P2,
    parameter int RUN_LEN = DEF_RUN_LEN,
    parameter int CW      = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stop,
    input  logic          hold,
    output logic          i0,
    output logic          i1,
    output logic          i2,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);
    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [CW-1:0] r_cycle;
    logic          r_busy;
    logic          r_done;
    logic          w_en;
    logic          w_init;
    logic          w_term;
    always_comb begin
        w_en   = (r_state == S_RUN) && !stop && !hold;
        w_term = w_en && (r_cycle == CW'(RUN_LEN - 1));
        w_init = stop || (start && r_state != S_RUN);
        w_next = stop ? S_IDLE :
                 (start && r_state != S_RUN) ? S_RUN :
                 w_term ? S_DONE : r_state;
    end
    // busy/done are separate flops so they never glitch on the two-bit RUN->DONE change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cycle <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cycle <= w_init ? '0 : w_en ? r_cycle + 1'b1 : r_cycle;
            r_busy  <= (w_next == S_RUN);
            r_done  <= (w_next == S_DONE);
        end
    end
    toggle_chan #(.P(P0), .CW(CW)) u_ch0 (.clk(clk), .reset(reset), .init(w_init), .en(w_en), .wave(i0));
    toggle_chan #(.P(P1), .CW(CW)) u_ch1 (.clk(clk), .reset(reset), .init(w_init), .en(w_en), .wave(i1));
    toggle_chan #(.P(P2), .CW(CW)) u_ch2 (.clk(clk), .reset(reset), .init(w_init), .en(w_en), .wave(i2));
    assign busy      = r_busy;
    assign done      = r_done;
    assign cycle_cnt = r_cycle;
endmodule

// File: tb/tb_toggle_stim_gen.sv
// tb_toggle_stim_gen: directed runs with time-stamped expectations checked by a negedge monitor.
module tb_toggle_stim_gen;
    logic        clk = 1'b0;
    logic        reset, start, stop, hold;
    logic        i0, i1, i2, busy, done;
    logic [11:0] cycle_cnt;
    int          g_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          base  = 0;
    bit          flush = 1'b0;
    int          exp_cyc[$];
    logic [16:0] exp_val[$];
    string       exp_nm[$];
    int          t0 = 0, t1 = 0, t2 = 0;
    logic        pb = 1'b0, pd = 1'b0, p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;

    toggle_stim_gen dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .hold(hold),
        .i0(i0), .i1(i1), .i2(i2), .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] vec(input logic a, b, c, bz, dn, input int cnt);
        return {a, b, c, bz, dn, cnt[11:0]};
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [16:0] a;
        g_cyc++;
        a = {i0, i1, i2, busy, done, cycle_cnt};
        if (busy && !pb) begin
            t0 = 0; t1 = 0; t2 = 0;
        end else if (pb) begin
            t0 += int'(i0 != p0);
            t1 += int'(i1 != p1);
            t2 += int'(i2 != p2);
        end
        if (done && !pd) begin
            cmp("i0_toggles", t0, 9);
            cmp("i1_toggles", t1, 81);
            cmp("i2_toggles", t2, 52);
        end
        while (exp_cyc.size() > 0 && (flush || exp_cyc[0] <= g_cyc)) begin
            if (exp_cyc[0] == g_cyc) cmp(exp_nm[0], {15'd0, a}, {15'd0, exp_val[0]});
            else cmp({exp_nm[0], "_missed"}, g_cyc, exp_cyc[0]);
            void'(exp_cyc.pop_front());
            void'(exp_val.pop_front());
            void'(exp_nm.pop_front());
        end
        pb = busy; pd = done; p0 = i0; p1 = i1; p2 = i2;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic want(input int k, input logic [16:0] v, input string nm);
        exp_cyc.push_back(base + k);
        exp_val.push_back(v);
        exp_nm.push_back(nm);
    endtask

    task automatic kick;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        // first full run from reset
        base = g_cyc + 2;
        want(-1,   vec(0,0,0,0,0,0),    "reset_state");
        want(0,    vec(0,0,0,1,0,0),    "a_c0");
        want(36,   vec(0,0,0,1,0,36),   "a_c36");
        want(37,   vec(0,1,0,1,0,37),   "a_i1_rise");
        want(56,   vec(0,1,0,1,0,56),   "a_c56");
        want(57,   vec(0,1,1,1,0,57),   "a_i2_rise");
        want(316,  vec(0,0,1,1,0,316),  "a_c316");
        want(317,  vec(1,0,1,1,0,317),  "a_i0_rise");
        want(2108, vec(0,0,0,1,0,2108), "a_c2108");
        want(2109, vec(0,1,1,1,0,2109), "a_i1_i2_same_edge");
        want(2999, vec(1,1,0,1,0,2999), "a_last_run");
        want(3000, vec(1,1,0,0,1,3000), "a_done");
        want(3005, vec(1,1,0,0,1,3000), "a_done_frozen");
        kick();
        repeat (3006) tick();
        // restart from DONE
        base = g_cyc + 2;
        want(-1,   vec(1,1,0,0,1,3000), "b_pre");
        want(0,    vec(0,0,0,1,0,0),    "b_c0");
        want(36,   vec(0,0,0,1,0,36),   "b_c36");
        want(37,   vec(0,1,0,1,0,37),   "b_i1_rise");
        want(3000, vec(1,1,0,0,1,3000), "b_done");
        kick();
        repeat (3002) tick();
        // hold for 10 cycles from RUN cycle 30, start pulse mid-run
        base = g_cyc + 2;
        want(-1,   vec(1,1,0,0,1,3000), "c_pre");
        want(30,   vec(0,0,0,1,0,30),   "c_hold_begin");
        want(35,   vec(0,0,0,1,0,30),   "c_hold_mid");
        want(40,   vec(0,0,0,1,0,30),   "c_hold_end");
        want(41,   vec(0,0,0,1,0,31),   "c_resume");
        want(46,   vec(0,0,0,1,0,36),   "c_c46");
        want(47,   vec(0,1,0,1,0,37),   "c_i1_rise_delayed");
        want(102,  vec(0,0,1,1,0,92),   "c_start_ignored");
        want(3009, vec(1,1,0,1,0,2999), "c_last_run");
        want(3010, vec(1,1,0,0,1,3000), "c_done_late");
        kick();
        repeat (30) tick();
        hold = 1'b1;
        repeat (10) tick();
        hold = 1'b0;
        repeat (60) tick();
        kick();
        repeat (2911) tick();
        // stop together with hold at RUN cycle 100
        base = g_cyc + 2;
        want(-1,  vec(1,1,0,0,1,3000), "d_pre");
        want(100, vec(0,0,1,1,0,100),  "d_c100");
        want(101, vec(0,0,0,0,0,0),    "d_stopped");
        want(103, vec(0,0,0,0,0,0),    "d_idle");
        kick();
        repeat (100) tick();
        stop = 1'b1; hold = 1'b1;
        tick();
        stop = 1'b0; hold = 1'b0;
        repeat (4) tick();
        // async reset mid-cycle at RUN cycle 500
        base = g_cyc + 2;
        want(-1,  vec(0,0,0,0,0,0),   "e_pre");
        want(499, vec(1,1,0,1,0,499), "e_c499");
        want(500, vec(0,0,0,0,0,0),   "e_reset_async");
        want(503, vec(0,0,0,0,0,0),   "e_reset_held");
        want(505, vec(0,0,0,0,0,0),   "e_idle_after_release");
        kick();
        repeat (500) tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (6) tick();
        // first run after reset release
        base = g_cyc + 2;
        want(-1, vec(0,0,0,0,0,0),  "f_pre");
        want(0,  vec(0,0,0,1,0,0),  "f_c0");
        want(37, vec(0,1,0,1,0,37), "f_i1_rise");
        kick();
        repeat (43) tick();
        flush = 1'b1;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
